// File: rtl/wb_cache.sv
// wb_cache: direct-mapped, write-back / write-allocate cache with one CPU request in flight.
// Define WB_CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module wb_cache #(
  parameter int NUM_ROWS        = 8,
  parameter int WORD_W          = 16,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int ADDR_W          = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_req_valid,
  output logic                              cpu_req_ready,
  input  logic                              cpu_we,
  input  logic [ADDR_W-1:0]                 cpu_addr,
  input  logic [WORD_W-1:0]                 cpu_wdata,
  output logic                              cpu_resp_valid,
  output logic [WORD_W-1:0]                 cpu_rdata,
  output logic                              cpu_err,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_req_we,
  output logic [ADDR_W-1:0]                 mem_req_addr,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic                              mem_resp_valid,
  input  logic [WORD_W*WORDS_PER_BLOCK-1:0] mem_rdata
`ifdef WB_CACHE_STATS_EN
  ,
  output logic [31:0]                       hit_count,
  output logic [31:0]                       miss_count
`endif
);

  localparam int BLOCK_W  = WORD_W * WORDS_PER_BLOCK;
  localparam int OFF_W    = $clog2(WORD_W / 8);
  localparam int SEL_W    = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W    = $clog2(NUM_ROWS);
  localparam int LINE_LSB = OFF_W + SEL_W;
  localparam int TAG_W    = ADDR_W - LINE_LSB - IDX_W;
  localparam int SEL_WS   = (SEL_W > 0) ? SEL_W : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESP} state_t;

  state_t                state_q, state_d;
  logic                  ready_en_q, ready_en_d;
  logic                  req_we_q, req_we_d;
  logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
  logic [WORD_W-1:0]     req_wdata_q, req_wdata_d;
  logic [WORD_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  refill_wait_q, refill_wait_d;
  logic                  relookup_q, relookup_d;
  logic [NUM_ROWS-1:0]   valid_q, valid_d;
  logic [NUM_ROWS-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_ROWS];
  logic [TAG_W-1:0]      tag_d  [NUM_ROWS];
  logic [BLOCK_W-1:0]    data_q [NUM_ROWS];
  logic [BLOCK_W-1:0]    data_d [NUM_ROWS];

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [SEL_WS-1:0]     req_sel;
  logic                  hit;
  logic                  misaligned;
`ifdef WB_CACHE_STATS_EN
  logic [31:0]           hit_count_q, hit_count_d;
  logic [31:0]           miss_count_q, miss_count_d;
`endif

  always_comb begin
    req_idx    = IDX_W'(req_addr_q >> LINE_LSB);
    req_tag    = TAG_W'(req_addr_q >> (LINE_LSB + IDX_W));
    req_sel    = SEL_WS'(req_addr_q >> OFF_W) & SEL_WS'(WORDS_PER_BLOCK - 1);
    hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    misaligned = (cpu_addr & ADDR_W'(WORD_W / 8 - 1)) != '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ready_en_q    <= 1'b0;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      refill_wait_q <= 1'b0;
      relookup_q    <= 1'b0;
      valid_q       <= '0;
      dirty_q       <= '0;
`ifdef WB_CACHE_STATS_EN
      hit_count_q   <= '0;
      miss_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ready_en_q    <= ready_en_d;
      req_we_q      <= req_we_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      refill_wait_q <= refill_wait_d;
      relookup_q    <= relookup_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
`ifdef WB_CACHE_STATS_EN
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
`endif
    end
  end

  // Tag and data storage is only meaningful where valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d       = state_q;
    ready_en_d    = 1'b1;
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    refill_wait_d = refill_wait_q;
    relookup_d    = relookup_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_d         = tag_q;
    data_d        = data_q;
`ifdef WB_CACHE_STATS_EN
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req_valid && cpu_req_ready) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          relookup_d  = 1'b0;
          err_d       = misaligned;
          if (misaligned) begin
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        // relookup_q marks the guaranteed hit after a refill, kept out of the stats.
        if (hit) begin
`ifdef WB_CACHE_STATS_EN
          if (!relookup_q && hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
`endif
          if (req_we_q) begin
            data_d[req_idx][int'(req_sel)*WORD_W +: WORD_W] = req_wdata_q;
            dirty_d[req_idx] = 1'b1;
            rdata_d = req_wdata_q;
          end else begin
            rdata_d = data_q[req_idx][int'(req_sel)*WORD_W +: WORD_W];
          end
          state_d = RESP;
        end else begin
`ifdef WB_CACHE_STATS_EN
          if (!relookup_q && miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
`endif
          refill_wait_d = 1'b0;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_req_ready) begin
          dirty_d[req_idx] = 1'b0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (!refill_wait_q) begin
          if (mem_req_ready) refill_wait_d = 1'b1;
        end else if (mem_resp_valid) begin
          data_d[req_idx]  = mem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          relookup_d       = 1'b1;
          state_d          = LOOKUP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready  = (state_q == IDLE) && ready_en_q;
    cpu_resp_valid = (state_q == RESP);
    cpu_rdata      = (state_q == RESP) ? rdata_q : '0;
    cpu_err        = (state_q == RESP) && err_q;
    mem_req_valid  = (state_q == WRITEBACK) || ((state_q == REFILL) && !refill_wait_q);
    mem_req_we     = (state_q == WRITEBACK);
    mem_req_addr   = '0;
    mem_wdata      = '0;
    if (state_q == WRITEBACK) begin
      mem_req_addr = ADDR_W'({tag_q[req_idx], req_idx}) << LINE_LSB;
      mem_wdata    = data_q[req_idx];
    end else if ((state_q == REFILL) && !refill_wait_q) begin
      mem_req_addr = ADDR_W'({req_tag, req_idx}) << LINE_LSB;
    end
`ifdef WB_CACHE_STATS_EN
    hit_count  = hit_count_q;
    miss_count = miss_count_q;
`endif
  end

endmodule
